// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM encoding and width constant for the I2C slave word receiver
//
// Contents:
//   I2C_BYTE_WIDTH : default number of bits per received word
//   i2c_state_e    : receiver FSM states (IDLE, WAIT_RISE, HIGH, DONE)

package i2c_pkg;

    localparam int I2C_BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        DONE      = 2'd3
    } i2c_state_e;

endpackage

// File: rtl/i2c_scl_edge_detect.sv
// rtl/i2c_scl_edge_detect.sv - optional SCL/SDA synchroniser plus SCL edge detector
//
// Ports:
//   clock     in   system clock
//   reset_n   in   asynchronous active-low reset
//   scl       in   raw I2C clock line
//   sda       in   raw I2C data line
//   scl_s     out  SCL as seen by the receiver logic
//   sda_s     out  SDA as seen by the receiver logic
//   scl_rise  out  one-cycle flag: SCL went 0 -> 1
//   scl_fall  out  one-cycle flag: SCL went 1 -> 0
//
// Build option I2C_SLAVE_READ_BYTE_SYNC_EN: when defined, scl and sda each pass
// through a two-flop synchroniser (reset value 1) before any other logic.

module i2c_scl_edge_detect
    import i2c_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall
);

`ifdef I2C_SLAVE_READ_BYTE_SYNC_EN
    logic [1:0] scl_sync_q;
    logic [1:0] scl_sync_d;
    logic [1:0] sda_sync_q;
    logic [1:0] sda_sync_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl};
        sda_sync_d = {sda_sync_q[0], sda};
    end

    // Reset to 1 so an idle (pulled-up) bus never looks like an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`else
    assign scl_s = scl;
    assign sda_s = sda;
`endif

    logic scl_last_q;
    logic scl_last_d;

    always_comb begin
        scl_last_d = scl_s;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_last_q <= 1'b1;
        end else begin
            scl_last_q <= scl_last_d;
        end
    end

    assign scl_rise = !scl_last_q &&  scl_s;
    assign scl_fall =  scl_last_q && !scl_s;

endmodule

// File: rtl/i2c_slave_read_byte.sv
// rtl/i2c_slave_read_byte.sv - slave-side I2C word receiver with SDA-stability abort
//
// Ports:
//   clock    in   system clock (much faster than SCL)
//   reset_n  in   asynchronous active-low reset
//   enable   in   start pulse, accepted only when idle
//   scl      in   I2C clock line
//   sda      in   I2C data line
//   data     out  last completed word, held until the next completion
//   finish   out  one-cycle pulse when data is updated
//   error    out  sticky abort flag, cleared by the next accepted enable
//   busy     out  high from accepted enable until finish or abort
//
// Parameters: DATA_WIDTH (>= 2), MSB_FIRST (1: first bit into data[DATA_WIDTH-1]).
// Build option I2C_SLAVE_READ_BYTE_SYNC_EN adds input synchronisers (see
// i2c_scl_edge_detect); all edge-relative latencies grow by 2 clocks.

module i2c_slave_read_byte
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_BYTE_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  scl,
    input  logic                  sda,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  finish,
    output logic                  error,
    output logic                  busy
);

    localparam int                CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]     LAST_BIT = CW'(DATA_WIDTH - 1);

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;

    i2c_scl_edge_detect u_edge (
        .clock    (clock),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    i2c_state_e            state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic                  bit_ref_q, bit_ref_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  finish_q,  finish_d;
    logic                  error_q,   error_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_ref_d = bit_ref_q;
        data_d    = data_q;
        finish_d  = 1'b0;
        error_d   = error_q;

        case (state_q)
            IDLE: begin
                // An SCL edge coinciding with enable is deliberately not sampled.
                if (enable) begin
                    error_d = 1'b0;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = WAIT_RISE;
                end
            end

            WAIT_RISE: begin
                // SDA may move freely while SCL is low; only the rising edge matters.
                if (scl_rise) begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], sda_s};
                    end else begin
                        shift_d = {sda_s, shift_q[DATA_WIDTH-1:1]};
                    end
                    bit_ref_d = sda_s;
                    state_d   = HIGH;
                end
            end

            HIGH: begin
                // SDA moving under high SCL is a START/STOP: drop the word.
                // A change coincident with the fall sees scl_s=0 and is legal.
                if (scl_s && (sda_s != bit_ref_q)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (scl_fall) begin
                    if (cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = WAIT_RISE;
                    end
                end
            end

            DONE: begin
                data_d   = shift_q;
                finish_d = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_ref_q <= 1'b0;
            data_q    <= '0;
            finish_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_ref_q <= bit_ref_d;
            data_q    <= data_d;
            finish_q  <= finish_d;
            error_q   <= error_d;
        end
    end

    assign data   = data_q;
    assign finish = finish_q;
    assign error  = error_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// tb/tb_i2c_slave_read_byte.sv - self-checking bench for i2c_slave_read_byte (MSB- and LSB-first instances)

module tb_i2c_slave_read_byte;

    localparam int H = 6;
`ifdef I2C_SLAVE_READ_BYTE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic       scl     = 1'b1;
    logic       sda     = 1'b1;
    logic [7:0] data_m, data_l;
    logic       finish_m, finish_l, error_m, error_l, busy_m, busy_l;

    always #5 clock = ~clock;

    i2c_slave_read_byte #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clock), .reset_n(reset_n), .enable(enable), .scl(scl), .sda(sda),
        .data(data_m), .finish(finish_m), .error(error_m), .busy(busy_m)
    );

    i2c_slave_read_byte #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset_n(reset_n), .enable(enable), .scl(scl), .sda(sda),
        .data(data_l), .finish(finish_l), .error(error_l), .busy(busy_l)
    );

    int vectors     = 0;
    int miscompares = 0;
    int fin_cnt     = 0;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] l;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Scoreboard consumer: every finish pulse must match the oldest pushed word.
    always @(negedge clock) begin
        if (finish_m || finish_l) begin
            exp_t e;
            fin_cnt++;
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_finish observed=%0h expected=%0h", data_m, 0);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_msb", data_m, e.m);
                check("data_lsb", data_l, e.l);
                check("finish_pair", finish_l, finish_m);
            end
        end
    end

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        tick(2);
        sda = b;
        tick(H);
        scl = 1'b1;
        tick(H);
        scl = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit mid_en, input string tag);
        exp_t e;
        e.m = w;
        e.l = rev8(w);
        sb.push_back(e);
        pulse_enable();
        check({tag, "_busy_start"}, {busy_m, busy_l}, 2'b11);
        check({tag, "_err_clear"}, {error_m, error_l}, 2'b00);
        if (scl) begin
            tick(H);
            scl = 1'b0;
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (mid_en && i == 4) begin
                pulse_enable();
                check({tag, "_busy_mid_en"}, {busy_m, busy_l}, 2'b11);
            end
        end
        tick(LAT - 1);
        check({tag, "_finish_early"}, finish_m, 1'b0);
        tick(1);
        check({tag, "_finish_lat"}, {finish_m, finish_l}, 2'b11);
        check({tag, "_busy_end"}, {busy_m, busy_l}, 2'b00);
        check({tag, "_err_end"}, {error_m, error_l}, 2'b00);
        tick(1);
        check({tag, "_finish_once"}, {finish_m, finish_l}, 2'b00);
    endtask

    initial begin
        int         fin_before;
        logic [7:0] prev_m, prev_l;

        tick(3);
        check("reset_outputs", {data_m, data_l, finish_m, finish_l, error_m, error_l, busy_m, busy_l}, 0);
        reset_n = 1'b1;
        tick(2);
        check("post_reset_idle", {finish_m, error_m, busy_m, busy_l}, 0);

        // SCL high at enable: the block must wait for a genuine rising edge.
        send_word(8'hA5, 1'b0, "w_a5");
        send_word(8'h00, 1'b0, "w_00");
        send_word(8'hFF, 1'b0, "w_ff");
        check("two_back_to_back", fin_cnt, 3);

        // SDA 0->1 while SCL high in the fourth bit (STOP) aborts the word.
        prev_m     = data_m;
        prev_l     = data_l;
        fin_before = fin_cnt;
        pulse_enable();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                send_bit(1'b1);
            end else begin
                tick(2);
                sda = 1'b0;
                tick(H);
                scl = 1'b1;
                tick(H / 2);
                sda = 1'b1;
                tick(LAT + 1);
                check("abort_error", {error_m, error_l}, 2'b11);
                check("abort_busy", {busy_m, busy_l}, 2'b00);
                tick(H);
                scl = 1'b0;
                tick(H);
            end
        end
        check("abort_data_m", data_m, prev_m);
        check("abort_data_l", data_l, prev_l);
        check("abort_no_finish", fin_cnt, fin_before);
        check("abort_err_sticky", error_m, 1'b1);

        // Enable while busy is ignored; next enable also clears the sticky error.
        send_word(8'h3C, 1'b1, "w_3c_mid_en");

        // Reset after six bits of a word.
        fin_before = fin_cnt;
        pulse_enable();
        for (int i = 7; i >= 2; i--) send_bit(1'b1);
        reset_n = 1'b0;
        tick(1);
        check("mid_reset_outputs", {data_m, data_l, finish_m, finish_l, error_m, error_l, busy_m, busy_l}, 0);
        reset_n = 1'b1;
        tick(2);
        check("mid_reset_no_finish", fin_cnt, fin_before);
        send_word(8'h81, 1'b0, "w_81");

        // Stream 1,0,0,0,0,0,0,0: MSB-first gives 0x80, LSB-first gives 0x01.
        send_word(8'h80, 1'b0, "w_stream");
        check("lsb_stream_data", data_l, 8'h01);

        tick(4);
        check("total_finishes", fin_cnt, 6);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_slave_read_byte.md
Name: i2c_slave_read_byte

Overview:
Slave-side receiver that assembles one I2C data/address word from SCL/SDA after the controller FSM grants it a start pulse. It sits directly downstream of the bus pins and directly upstream of the slave ACK/byte-handling FSM. It performs per-bit SCL-edge sampling internally, checks that SDA is stable while SCL is high, and hands over the completed word with a one-cycle finish pulse. Any SDA change during SCL high (a START or STOP on the bus) aborts the word and raises error.

Parameters:
DATA_WIDTH, 8, number of bits per word; must be ≥2.
MSB_FIRST, 1, 1 = first received bit lands in data[DATA_WIDTH-1]; 0 = first bit lands in data[0].

Ports:
clock  input  1  system clock; must be much faster than SCL.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  start pulse; accepted only in IDLE; ignored while busy.
scl  input  1  I2C clock line (already resolved 0/1).
sda  input  1  I2C data line (already resolved 0/1).
data  output  DATA_WIDTH  last completed word; holds its value until the next successful completion.
finish  output  1  single-cycle pulse when data is updated.
error  output  1  sticky abort flag; cleared by the next accepted enable.
busy  output  1  high from an accepted enable until finish or abort.

Behaviour:
- Reset values: data=0, finish=0, error=0, busy=0, FSM=IDLE, bit counter=0, shift register=0, scl_last=1.
- scl_rise = !scl_last & scl; scl_fall = scl_last & !scl; scl_last is registered every cycle.
- FSM states:
  - IDLE: busy=0. On enable: clear error, counter=0, shift=0, go WAIT_RISE.
  - WAIT_RISE: on scl_rise, sample sda into the shift register (direction set by MSB_FIRST), store the sampled bit in bit_ref, go HIGH. SDA activity while SCL is low is legal.
  - HIGH: if scl=1 and sda!=bit_ref, set error=1, go IDLE (abort; shift discarded; no finish). On scl_fall: if counter==DATA_WIDTH-1, go DONE; otherwise increment the counter and go WAIT_RISE.
  - DONE: data<=shift, finish=1 for exactly one cycle, go IDLE.
- Latency: finish asserts 2 clocks after the clock edge that sees the SCL falling edge of the last bit (HIGH→DONE, then DONE registers data/finish).
- Counter width: $clog2(DATA_WIDTH); no wrap, because the counter resets on every enable.
- The enable and scl_rise same-cycle case in IDLE: the enable moves the FSM to WAIT_RISE; that edge is not sampled. The upstream FSM pulses enable while SCL is low.
- If scl is already high when enable arrives, the block waits for the next genuine rising edge.
- Abort on the same cycle as scl_fall (sda change and fall together): scl=0 in that cycle, so no error is raised and the fall is taken.
- Reset mid-word: everything returns immediately to reset values; no finish.
- data is never partially updated.

Optional Feature:
I2C_SLAVE_READ_BYTE_SYNC_EN: when defined, scl and sda each pass through a 2-flop synchroniser (reset value 1) before all logic. This adds 2 clocks to every edge-relative latency. When undefined, scl and sda are used directly (the caller guarantees they are synchronous). Port list is identical in both builds.

Decomposition:
- Shared package i2c_pkg: FSM state encoding (IDLE, WAIT_RISE, HIGH, DONE) and the default width constant I2C_BYTE_WIDTH=8.
- Natural sub-module i2c_scl_edge_detect: optional synchroniser, scl_last register, scl_rise/scl_fall outputs.
- The FSM and shift register stay in this module.

Test Plan:
- enable, then send 0xA5 MSB-first with SDA stable during SCL high → finish pulse once, data=0xA5, error=0, busy falls with finish.
- Back-to-back words 0x00 then 0xFF with enable between them → data=0x00 then 0xFF, exactly two finish pulses.
- SDA 0→1 while SCL high during bit 3 (STOP) → error=1, busy=0, no finish, data keeps its previous value; next enable clears error.
- enable pulsed while busy mid-word → ignored; word 0x3C still completes correctly.
- reset_n asserted after bit 5 → all outputs return to 0 next cycle; a subsequent full word 0x81 is received correctly.
- MSB_FIRST=0, DATA_WIDTH=8, bit stream 1,0,0,0,0,0,0,0 → data=0x01; repeat with I2C_SLAVE_READ_BYTE_SYNC_EN → same data, finish 2 clocks later.
